// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction fetch queue.
//   WORD_W       : instruction / address width (32)
//   DEF_DEPTH    : default queue depth
//   DEF_RESET_PC : default first fetch address
//   fetch_state_e: fetch FSM states
//   align_pc()   : force a byte address onto a word boundary
package fetch_pkg;

  localparam int                WORD_W       = 32;
  localparam int                DEF_DEPTH    = 4;
  localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;

  // IDLE: no request. WAIT: request live, response kept.
  // KILL: request live, response discarded (a redirect overtook it).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } fetch_state_e;

  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
    return {pc[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if -- memory-side and decode-side handshake bundle.
//   master : the fetch queue (drives imem_req_o/imem_addr_o, instr_valid_o/instr_o/pc_o)
//   slave  : the environment (memory + decode + redirect source)
interface instr_fetch_queue_if;

  logic                        imem_req_o;
  logic [fetch_pkg::WORD_W-1:0] imem_addr_o;
  logic                        imem_ack_i;
  logic [fetch_pkg::WORD_W-1:0] imem_data_i;
  logic                        instr_valid_o;
  logic [fetch_pkg::WORD_W-1:0] instr_o;
  logic [fetch_pkg::WORD_W-1:0] pc_o;
  logic                        instr_ready_i;
  logic                        redirect_i;
  logic [fetch_pkg::WORD_W-1:0] redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    input  imem_ack_i, imem_data_i, instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    output imem_ack_i, imem_data_i, instr_ready_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo -- DEPTH-entry register FIFO holding {pc, instr} pairs.
//   clk_i, rst_i  : clock, async active-high reset (clears storage)
//   push_i/data_i : write one entry
//   pop_i         : retire head entry (caller guarantees non-empty)
//   flush_i       : empty the queue; wins over push/pop
//   head_o        : registered head entry
//   count_o       : current occupancy 0..DEPTH
module fetch_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 64,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [CNT_W-1:0]  cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue -- fetches sequential instruction words from memory into a
// small queue feeding decode, with branch/jump redirect flush.
//   clk_i, rst_i : clock, async active-high reset
//   bus (master) : imem_req_o/imem_addr_o/imem_ack_i/imem_data_i memory side,
//                  instr_valid_o/instr_o/pc_o/instr_ready_i decode side,
//                  redirect_i/redirect_pc_i flush request
//   stall_cnt_o  : cycles with no valid head instruction (only when the
//                  FETCH_STALL_CNT_EN macro is defined)
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  instr_fetch_queue_if.master       bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [WORD_W-1:0]         stall_cnt_o
`endif
);

  localparam int               CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  fetch_state_e      state_q;
  logic [WORD_W-1:0] fetch_pc_q, addr_q;
  logic              req_q;

  logic [CNT_W-1:0]  count;
  logic [2*WORD_W-1:0] head;
  logic              valid, pop, ack, push;
  logic [CNT_W-1:0]  cnt_after;

  assign valid     = (count != '0);
  assign pop       = valid && bus.instr_ready_i && !bus.redirect_i;
  assign ack       = req_q && bus.imem_ack_i;
  assign push      = (state_q == S_WAIT) && ack && !bus.redirect_i;
  assign cnt_after = count + CNT_W'(push) - CNT_W'(pop);

  fetch_fifo #(.DEPTH(DEPTH), .DATA_W(2*WORD_W)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i ({addr_q, bus.imem_data_i}),
    .pop_i       (pop),
    .flush_i     (bus.redirect_i),
    .head_o      (head),
    .count_o     (count)
  );

  // addr_q is separate from fetch_pc_q: in KILL the old address must stay on
  // the bus until ack while fetch_pc_q already holds the redirect target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      if (bus.redirect_i) fetch_pc_q <= align_pc(bus.redirect_pc_i);
      case (state_q)
        S_IDLE: begin
          if (!bus.redirect_i && count < FULL) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end
        S_WAIT: begin
          if (bus.redirect_i) begin
            if (ack) begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end else begin
              state_q <= S_KILL;
            end
          end else if (ack) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            addr_q     <= fetch_pc_q + 32'd4;
            // Keep streaming only while the accepted word leaves room.
            if (cnt_after >= FULL) begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        S_KILL: begin
          if (ack) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_o    = req_q;
  assign bus.imem_addr_o   = addr_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = head[WORD_W-1:0];
  assign bus.pc_o          = head[2*WORD_W-1:WORD_W];

`ifdef FETCH_STALL_CNT_EN
  logic [WORD_W-1:0] stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     stall_q <= '0;
    else if (!valid && ~&stall_q)  stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH SHALL be: DEPTH, 4, queue entries, power of two, 2..16.
REQ-002 Parameter RESET_PC SHALL be: RESET_PC, 32'h0000_0000, first fetch address.
REQ-003 Port clk_i SHALL be: clk_i  in  1  sole clock, rising edge.
REQ-004 Port rst_i SHALL be: rst_i  in  1  reset, asynchronous, active-high.
REQ-005 Port imem_req_o SHALL be: imem_req_o  out  1  fetch request to instruction memory.
REQ-006 Port imem_addr_o SHALL be: imem_addr_o  out  32  fetch byte address, word aligned.
REQ-007 Port imem_ack_i SHALL be: imem_ack_i  in  1  memory returns data this cycle.
REQ-008 Port imem_data_i SHALL be: imem_data_i  in  32  returned instruction word.
REQ-009 Port instr_valid_o SHALL be: instr_valid_o  out  1  head entry valid to decode.
REQ-010 Port instr_o SHALL be: instr_o  out  32  head instruction.
REQ-011 Port pc_o SHALL be: pc_o  out  32  address of head instruction.
REQ-012 Port instr_ready_i SHALL be: instr_ready_i  in  1  decode consumes head.
REQ-013 Port redirect_i SHALL be: redirect_i  in  1  branch/jump flush request.
REQ-014 Port redirect_pc_i SHALL be: redirect_pc_i  in  32  new fetch address; bits [1:0] ignored, forced 00.

Function
REQ-015 Memory handshake SHALL be: transfer when imem_req_o && imem_ack_i; imem_req_o and imem_addr_o held stable until ack; at most one request outstanding; zero-wait ack (same cycle as req) legal.
REQ-016 FSM SHALL have states IDLE (no request), WAIT (request live, response kept), KILL (request live, response discarded).
REQ-017 IDLE -> WAIT SHALL occur when not redirect_i and count < DEPTH; imem_addr_o = fetch_pc.
REQ-018 In WAIT on ack, the block SHALL push {fetch_pc, imem_data_i}, fetch_pc += 4 (wraps modulo 2^32), and stay WAIT if count_after_push_and_pop < DEPTH, else go IDLE.
REQ-019 Decode handshake SHALL be: pop when instr_valid_o && instr_ready_i; instr_valid_o = (count != 0); instr_o/pc_o driven from registered head entry; push and pop same cycle permitted, count unchanged.
REQ-020 Pushed data SHALL appear at instr_o no earlier than the cycle after ack (1-cycle fill latency).
REQ-021 On redirect_i the block SHALL empty the queue (instr_valid_o = 0 next cycle, pending pop ignored) and load fetch_pc = {redirect_pc_i[31:2], 2'b00}.
REQ-022 redirect_i in WAIT without ack SHALL move to KILL; req/addr stay held until ack.
REQ-023 redirect_i in WAIT with ack, or in KILL with ack, SHALL drop the response and go IDLE.
REQ-024 In KILL without redirect, the block SHALL drop the response on ack and go IDLE; redirect in KILL without ack SHALL update fetch_pc and stay KILL.
REQ-025 Queue overflow SHALL be impossible by construction; push when full is a design error.

Reset
REQ-026 While rst_i is high: state=IDLE, count=0, fetch_pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, stall counter=0.
REQ-027 First request SHALL assert in the first clock edge after rst_i deasserts; reset mid-transfer SHALL abandon the request without waiting for ack.

Configuration
REQ-028 Macro FETCH_STALL_CNT_EN defined: add output stall_cnt_o (32) counting cycles with instr_valid_o==0 outside reset, saturating at 32'hFFFF_FFFF, cleared only by reset.
REQ-029 Macro undefined: no stall_cnt_o port and no counter logic; all other behaviour identical.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the FSM state enum, word width 32, default DEPTH and RESET_PC.
REQ-031 Storage SHALL be a sub-module fetch_fifo (DEPTH x 64-bit, push/pop/flush, count output).

Verification
REQ-032 Zero-wait memory, ready=1: instructions at PCs 0,4,8,C delivered in order, one per cycle after 2-cycle start-up.
REQ-033 ack delayed 3 cycles, ready=0: after 4 fetches queue full, imem_req_o=0, imem_addr_o stable during each wait.
REQ-034 redirect_i with redirect_pc_i=32'h0000_0103 while WAIT: enter KILL, stale word dropped, next request addr 32'h0000_0100, instr_valid_o=0 next cycle.
REQ-035 redirect_i and ack in same cycle: response dropped, IDLE, next fetch from redirect address.
REQ-036 rst_i pulsed mid-WAIT: all outputs to reset values immediately; restart fetch at RESET_PC.
REQ-037 With FETCH_STALL_CNT_EN, ready=1, ack every 3rd cycle: stall_cnt_o increments on every empty cycle, exactly 2 per delivered instruction in steady state.
